// File: rtl/bf_program_loader.sv
// bf_program_loader: takes ASCII characters from the board switches,
// encodes the Brainfuck commands into opcodes and writes them one by one
// into program memory. When the user ends the program it appends END,
// checks bracket balance and signals the control unit.
module bf_program_loader #(
  parameter int PMAW = 8,
  parameter int OPW  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      char_in,
  input  logic            char_strobe,
  input  logic            load_end,
  output logic [PMAW-1:0] pm_address,
  output logic [OPW-1:0]  pm_data,
  output logic            pm_wren,
  output logic            PMInputDone,
  output logic [PMAW-1:0] prog_len,
  output logic            error,
  output logic [1:0]      error_code
);

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    WRITE_END = 2'd1,
    DONE      = 2'd2,
    ERROR     = 2'd3
  } state_t;

  localparam logic [OPW-1:0]  OP_END  = OPW'(0);
  localparam logic [OPW-1:0]  OP_INC  = OPW'(1);
  localparam logic [OPW-1:0]  OP_DEC  = OPW'(2);
  localparam logic [OPW-1:0]  OP_RGT  = OPW'(3);
  localparam logic [OPW-1:0]  OP_LFT  = OPW'(4);
  localparam logic [OPW-1:0]  OP_OPEN = OPW'(5);
  localparam logic [OPW-1:0]  OP_CLS  = OPW'(6);
  localparam logic [OPW-1:0]  OP_OUT  = OPW'(7);
  localparam logic [OPW-1:0]  OP_IN   = OPW'(8);

  // Last word is kept free so END always fits.
  localparam logic [PMAW-1:0] WP_LAST = '1;
  localparam logic [PMAW-1:0] ZERO    = '0;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNMATCH  = 2'd1;
  localparam logic [1:0] ERR_UNCLOSED = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  state_t          state;
  logic [PMAW-1:0] wp;
  logic [PMAW-1:0] depth;
  logic            endPending;
  logic            strobePrev;
  logic            endPrev;

  logic            charEvt;
  logic            endEvt;
  logic            cmdValid;
  logic            isOpen;
  logic            isClose;
  logic [OPW-1:0]  cmdOp;

  // Rising-edge events against the previous sample of each level input.
  assign charEvt = char_strobe & ~strobePrev;
  assign endEvt  = load_end & ~endPrev;

  // Character-to-opcode decode; anything not a command is a comment.
  always_comb begin
    cmdValid = 1'b1;
    isOpen   = 1'b0;
    isClose  = 1'b0;
    cmdOp    = OP_END;
    case (char_in)
      8'h2B: cmdOp = OP_INC;                    // '+'
      8'h2D: cmdOp = OP_DEC;                    // '-'
      8'h3E: cmdOp = OP_RGT;                    // '>'
      8'h3C: cmdOp = OP_LFT;                    // '<'
      8'h5B: begin cmdOp = OP_OPEN; isOpen = 1'b1; end   // '['
      8'h5D: begin cmdOp = OP_CLS; isClose = 1'b1; end   // ']'
      8'h2E: cmdOp = OP_OUT;                    // '.'
      8'h2C: cmdOp = OP_IN;                     // ','
      default: cmdValid = 1'b0;
    endcase
  end

  // Loader FSM with registered memory-write and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= LOAD;
      wp          <= ZERO;
      depth       <= ZERO;
      endPending  <= 1'b0;
      strobePrev  <= 1'b0;
      endPrev     <= 1'b0;
      pm_address  <= ZERO;
      pm_data     <= OP_END;
      pm_wren     <= 1'b0;
      PMInputDone <= 1'b0;
      prog_len    <= ZERO;
      error       <= 1'b0;
      error_code  <= ERR_NONE;
    end else begin
      strobePrev <= char_strobe;
      endPrev    <= load_end;
      pm_wren    <= 1'b0;
      case (state)
        LOAD: begin
          if (endPending) begin
            // A character arrived together with load_end last cycle and
            // has been written; no new edge can occur this cycle.
            endPending <= 1'b0;
            state      <= WRITE_END;
          end else begin
            if (charEvt && cmdValid) begin
              if (wp == WP_LAST) begin
                state      <= ERROR;
                error      <= 1'b1;
                error_code <= ERR_OVERFLOW;
              end else if (isClose && (depth == ZERO)) begin
                state      <= ERROR;
                error      <= 1'b1;
                error_code <= ERR_UNMATCH;
              end else begin
                pm_address <= wp;
                pm_data    <= cmdOp;
                pm_wren    <= 1'b1;
                wp         <= wp + 1'b1;
                prog_len   <= wp + 1'b1;
                if (isOpen)  depth <= depth + 1'b1;
                if (isClose) depth <= depth - 1'b1;
              end
            end
            if (endEvt) begin
              // Let the character finish first; an ERROR it raises wins
              // because endPending is only looked at in LOAD.
              if (charEvt && cmdValid) endPending <= 1'b1;
              else                     state      <= WRITE_END;
            end
          end
        end
        WRITE_END: begin
          if (depth != ZERO) begin
            state      <= ERROR;
            error      <= 1'b1;
            error_code <= ERR_UNCLOSED;
          end else begin
            pm_address <= wp;
            pm_data    <= OP_END;
            pm_wren    <= 1'b1;
            prog_len   <= wp;
            state      <= DONE;
          end
        end
        DONE: begin
          // Raised one cycle after the END write so memory already holds it.
          PMInputDone <= 1'b1;
        end
        default: begin
          // ERROR: sticky until reset, no writes.
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/bf_program_loader.md
# bf_program_loader

Front-end loader that fills program memory before the Brainfuck machine runs. It accepts ASCII characters one at a time from the board switches and drops non-Brainfuck characters as comments. Each Brainfuck command is encoded to a 4-bit opcode and written sequentially into program memory. When the user ends the program, the block appends an END opcode, checks bracket balance, and raises `PMInputDone` toward the control unit.

## Interface
Parameters:
- `PMAW`, 8, program-memory address width; capacity is 2^PMAW words.
- `OPW`, 4, opcode width.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; returns the block to LOAD and clears all state.
- `char_in`  in  8  ASCII character from `DataInputSwitches`.
- `char_strobe`  in  1  level input; a rising edge submits `char_in`.
- `load_end`  in  1  level input; a rising edge terminates the program.
- `pm_address`  out  PMAW  write address to program memory.
- `pm_data`  out  OPW  opcode to write.
- `pm_wren`  out  1  one-cycle write strobe.
- `PMInputDone`  out  1  high once the program is loaded without error; held until reset.
- `prog_len`  out  PMAW  number of opcodes written, END excluded.
- `error`  out  1  high in the ERROR state.
- `error_code`  out  2  0 = none, 1 = unmatched `]`, 2 = unclosed `[`, 3 = overflow.

## Operation
- Opcode encoding:
  - END = 0x0, `+` = 0x1, `-` = 0x2, `>` = 0x3, `<` = 0x4.
  - `[` = 0x5, `]` = 0x6, `.` = 0x7, `,` = 0x8.
  - Every other character is ignored: no write and no address change.
- Edge detection: registered copies of `char_strobe` and `load_end`; an event is `in & ~prev`. The registers are cleared by reset.
- Internal state: write pointer `wp` (PMAW bits), bracket depth `depth` (PMAW bits), flag `end_pending`.
- States: LOAD, WRITE_END, DONE, ERROR.
- LOAD, on a char event carrying a valid command:
  - If `wp` = 2^PMAW-1 → ERROR, code 3, no write. The last word is reserved for END.
  - If the character is `]` and `depth` = 0 → ERROR, code 1, no write.
  - Otherwise write the opcode at `wp`, then `wp`+1.
  - `[` does `depth`+1; `]` does `depth`-1.
- LOAD, on a load_end event → WRITE_END.
- LOAD, char event and load_end event in the same cycle: the character is processed first and `end_pending` is set. Next cycle the block goes to WRITE_END, unless the character caused ERROR, in which case ERROR wins.
- WRITE_END:
  - If `depth` ≠ 0 → ERROR, code 2, no write.
  - Otherwise write 0x0 at `wp`, then → DONE. `wp` is not incremented, so `prog_len` = `wp`.
- DONE: `PMInputDone` = 1. All inputs are ignored.
- ERROR: `error` = 1 and `error_code` holds its value. All inputs are ignored and there are no writes. Only reset exits ERROR.
- An empty program (load_end with no commands) writes END at address 0 and reaches DONE with `prog_len` = 0.

## Timing
- All outputs are registered.
- Reset values:
  - State LOAD.
  - `pm_address` = 0, `pm_data` = 0, `pm_wren` = 0.
  - `PMInputDone` = 0, `prog_len` = 0, `error` = 0, `error_code` = 0.
  - `wp` = 0, `depth` = 0, `end_pending` = 0.
- Write latency:
  - A strobe rising edge sampled at clock edge N produces `pm_wren` = 1 with `pm_address`/`pm_data` valid in cycle N+1, for exactly one cycle.
  - `prog_len` updates in the same cycle as the write.
- END latency:
  - A load_end edge sampled at edge N moves the state to WRITE_END after edge N.
  - The END write is visible in cycle N+2.
  - `PMInputDone` rises in cycle N+3, the cycle after the END write, so memory already holds END when control starts.
- ERROR latency: `error` and `error_code` rise in the cycle after the offending event.
- Throughput: at most one character per 2 cycles, since an edge requires a low sample in between.
- `pm_address` holds its last value when `pm_wren` = 0.
- Reset mid-load:
  - Takes effect on the next edge and drops `PMInputDone` and `error`.
  - Program memory contents are not cleared; they are overwritten on the next load.

## Test plan
- Feed "+[->+<]." then load_end → writes 1,5,2,3,1,4,6,7 at 0..7, then END at 8; `prog_len` = 8; `PMInputDone` = 1 two cycles after the END write edge.
- Feed "a+ b\n-" then load_end → only 0x1@0, 0x2@1, END@2 are written; `prog_len` = 2; no writes for the comment characters.
- Feed "]" → `error` = 1, `error_code` = 1, no `pm_wren`; a later load_end is ignored and `PMInputDone` stays 0.
- Feed "[[]" then load_end → 3 writes, then `error_code` = 2 with no END write.
- Feed 255 `+` then one more `+` → `error_code` = 3 and no write at address 255. A separate run of 255 `+` followed by load_end → END@255 and `prog_len` = 255.
- Raise char_strobe (`.`) and load_end on the same cycle → 0x7@0, then END@1, then DONE. Separately, assert reset during a load → all outputs return to their reset values and a new load starts at address 0.
